// File: rtl/display_arb_pkg.sv
// Shared types and constants for the display character arbiter.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package display_arb_pkg;

  // Terminal handshake sequencer states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  // Lowercase ASCII range and the offset that maps it to uppercase.
  localparam logic [6:0] LC_LO    = 7'h61;
  localparam logic [6:0] LC_HI    = 7'h7A;
  localparam logic [6:0] CASE_OFS = 7'h20;

  // Requester identifiers, also used as the round-robin "served last" bit.
  localparam logic SRC_CPU = 1'b0;
  localparam logic SRC_KBD = 1'b1;

  // Fold a-z to A-Z; every other code passes through.
  function automatic logic [6:0] fold_case(input logic [6:0] code);
    logic [6:0] res;
    res = code;
    if (code >= LC_LO && code <= LC_HI) res = code - CASE_OFS;
    return res;
  endfunction

endpackage

// File: rtl/kbd_fifo.sv
// Synchronous FIFO with full/empty flags and same-cycle push/pop.
// Latency: a pushed word appears on o_dout the cycle after its push edge.
// Backpressure: a push while full is ignored unless a pop occurs in the same cycle.
module kbd_fifo #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_dout    = r_mem[r_rd_ptr];
  // A pop frees a slot before the push needs it, so full+pop+push is legal.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Storage array; occupancy gates what is visible, so no reset is needed.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

  // Read/write pointers and occupancy count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/display_char_arbiter.sv
// Shares the terminal character handshake between the PIA display port and keyboard local echo.
// Latency: keyboard strobe to vt_da 3 edges; cpu_da rise to vt_da 5 edges (terminal ready).
// Backpressure: CPU held off via cpu_rda; keyboard buffered in a FIFO, overflow drops and pulses.
module display_char_arbiter
  import display_arb_pkg::*;
#(
  parameter int KBD_DEPTH   = 4,
  parameter int ACK_TIMEOUT = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] cpu_rd,
  input  logic       cpu_da,
  output logic       cpu_rda,
  input  logic       kbd_new,
  input  logic [6:0] kbd_code,
  input  logic       local_echo,
  output logic [6:0] vt_rd,
  output logic       vt_da,
  input  logic       vt_rdy,
  output logic       kbd_overflow,
  output logic       vt_timeout
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  // Synchronizers and edge detect for the asynchronous PIA pins.
  logic       r_da_s1, r_da_s2, r_da_s3;
  logic [6:0] r_rd_s1, r_rd_s2;
  logic       w_da_rise;

  // CPU holding register.
  logic [6:0] r_cpu_char;
  logic       r_cpu_pend;
  logic       r_cpu_rda;

  // Keyboard FIFO interface.
  logic       w_kbd_push;
  logic       w_kbd_pop;
  logic       w_kbd_drop;
  logic [6:0] w_kbd_folded;
  logic [6:0] w_fifo_dout;
  logic       w_fifo_full;
  logic       w_fifo_empty;
  logic       r_kbd_overflow;

  // Sequencer.
  state_t             r_state, w_next;
  logic               r_src;
  logic               r_rr_last;
  logic [CNT_W-1:0]   r_cnt;
  logic [6:0]         r_vt_rd;
  logic               r_vt_da;
  logic               r_vt_timeout;
  logic               w_grant;
  logic               w_grant_src;
  logic               w_done;
  logic               w_tmo;

  assign w_da_rise    = r_da_s2 && !r_da_s3;
  assign w_kbd_folded = fold_case(kbd_code);
  assign w_kbd_push   = kbd_new && local_echo;
  assign w_kbd_pop    = w_done && (r_src == SRC_KBD);
  assign w_kbd_drop   = w_kbd_push && w_fifo_full && !w_kbd_pop;

  assign cpu_rda      = r_cpu_rda;
  assign vt_rd        = r_vt_rd;
  assign vt_da        = r_vt_da;
  assign kbd_overflow = r_kbd_overflow;
  assign vt_timeout   = r_vt_timeout;

  // Two-flop synchronizers plus one delayed copy of DA for rise detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_da_s1 <= 1'b0;
      r_da_s2 <= 1'b0;
      r_da_s3 <= 1'b0;
      r_rd_s1 <= '0;
      r_rd_s2 <= '0;
    end else begin
      r_da_s1 <= cpu_da;
      r_da_s2 <= r_da_s1;
      r_da_s3 <= r_da_s2;
      r_rd_s1 <= cpu_rd;
      r_rd_s2 <= r_rd_s1;
    end
  end

  // Capture a CPU character on a DA rise; re-open only after delivery and DA low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cpu_char <= '0;
      r_cpu_pend <= 1'b0;
      r_cpu_rda  <= 1'b1;
    end else if (w_da_rise && r_cpu_rda) begin
      r_cpu_char <= r_rd_s2;
      r_cpu_pend <= 1'b1;
      r_cpu_rda  <= 1'b0;
    end else begin
      if (w_done && (r_src == SRC_CPU)) r_cpu_pend <= 1'b0;
      if (!r_cpu_rda && !r_cpu_pend && !r_da_s2) r_cpu_rda <= 1'b1;
    end
  end

  kbd_fifo #(
    .WIDTH (7),
    .DEPTH (KBD_DEPTH)
  ) u_kbd_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_kbd_push),
    .i_din   (w_kbd_folded),
    .i_pop   (w_kbd_pop),
    .o_dout  (w_fifo_dout),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // Overflow pulse follows the cycle in which a keyboard character is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_kbd_overflow <= 1'b0;
    else     r_kbd_overflow <= w_kbd_drop;
  end

  // Next-state, grant selection and completion decode.
  always_comb begin
    w_next      = r_state;
    w_grant     = 1'b0;
    w_grant_src = SRC_CPU;
    w_done      = 1'b0;
    w_tmo       = 1'b0;
    case (r_state)
      IDLE: begin
        // Only start a character when the terminal reports itself ready.
        if (vt_rdy && (r_cpu_pend || !w_fifo_empty)) begin
          w_grant = 1'b1;
          w_next  = SEND;
          if (r_cpu_pend && !w_fifo_empty)
            w_grant_src = (r_rr_last == SRC_CPU) ? SRC_KBD : SRC_CPU;
          else
            w_grant_src = w_fifo_empty ? SRC_CPU : SRC_KBD;
        end
      end
      SEND: begin
        // vt_rdy is only trusted as an acknowledge once vt_da has been driven high.
        if (r_vt_da && !vt_rdy) begin
          w_next = RELEASE;
        end else if (r_cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
          w_tmo  = 1'b1;
          w_done = 1'b1;
          w_next = IDLE;
        end
      end
      RELEASE: begin
        if (vt_rdy) begin
          w_done = 1'b1;
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Terminal outputs, timeout counter and round-robin bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_src        <= SRC_CPU;
      r_rr_last    <= SRC_CPU;
      r_cnt        <= '0;
      r_vt_rd      <= '0;
      r_vt_da      <= 1'b0;
      r_vt_timeout <= 1'b0;
    end else begin
      if (w_grant) begin
        r_src   <= w_grant_src;
        r_vt_rd <= (w_grant_src == SRC_KBD) ? w_fifo_dout : r_cpu_char;
        r_cnt   <= '0;
      end else if (r_state == SEND) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      r_vt_da      <= (r_state == SEND) && (w_next == SEND);
      r_vt_timeout <= w_tmo;
      if (w_done) r_rr_last <= r_src;
    end
  end

endmodule

// File: tb/tb_display_char_arbiter.sv
// Self-checking bench for display_char_arbiter with a behavioural terminal model.
// Latency: n/a.
// Backpressure: the terminal model drives vt_rdy (handshake or forced level).
module tb_display_char_arbiter;

  localparam int DEPTH = 4;
  localparam int TMO   = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] cpu_rd;
  logic       cpu_da;
  logic       cpu_rda;
  logic       kbd_new;
  logic [6:0] kbd_code;
  logic       local_echo;
  logic [6:0] vt_rd;
  logic       vt_da;
  logic       vt_rdy;
  logic       kbd_overflow;
  logic       vt_timeout;

  display_char_arbiter #(
    .KBD_DEPTH   (DEPTH),
    .ACK_TIMEOUT (TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_rd       (cpu_rd),
    .cpu_da       (cpu_da),
    .cpu_rda      (cpu_rda),
    .kbd_new      (kbd_new),
    .kbd_code     (kbd_code),
    .local_echo   (local_echo),
    .vt_rd        (vt_rd),
    .vt_da        (vt_da),
    .vt_rdy       (vt_rdy),
    .kbd_overflow (kbd_overflow),
    .vt_timeout   (vt_timeout)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state: characters the terminal saw, and the expected sequence.
  logic [6:0] dq[$];
  logic [6:0] exp_q[$];
  int         tmode;       // 0 = handshake terminal, 1 = vt_rdy forced to fval
  logic       fval;
  bit         fixed_dly;
  bit         m_last_kbd;  // which requester the model believes was served last
  int         ovf_cnt;
  int         tmo_cnt;
  logic [6:0] m_got;
  int         hd1, hd2;

  function automatic logic [6:0] fold(input logic [6:0] c);
    if (c >= 7'h61 && c <= 7'h7A) return c - 7'd32;
    return c;
  endfunction

  // Terminal model: accept on vt_da, drop ready after hd1 cycles, raise it hd2 later.
  initial begin
    vt_rdy = 1'b1;
    forever begin
      @(negedge clk);
      if (tmode == 1) begin
        vt_rdy = fval;
      end else if (vt_da === 1'b1 && rst === 1'b0) begin
        m_got = vt_rd;
        dq.push_back(m_got);
        hd1 = fixed_dly ? 3 : $urandom_range(1, 4);
        hd2 = fixed_dly ? 10 : $urandom_range(1, 8);
        repeat (hd1 - 1) begin
          @(negedge clk);
          check_eq("vt_da_hold", vt_da, 1);
          check_eq("vt_rd_stable", vt_rd, m_got);
        end
        vt_rdy = 1'b0;
        @(negedge clk);
        check_eq("vt_da_fall", vt_da, 0);
        repeat (hd2) begin
          @(negedge clk);
          check_eq("vt_rd_release", vt_rd, m_got);
        end
        vt_rdy = 1'b1;
      end else begin
        vt_rdy = 1'b1;
      end
    end
  end

  // Pulse counters.
  initial begin
    forever begin
      @(negedge clk);
      if (kbd_overflow === 1'b1) ovf_cnt++;
      if (vt_timeout === 1'b1) tmo_cnt++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic kbd_strobe(input logic [6:0] c, input logic echo);
    @(negedge clk);
    kbd_new    = 1'b1;
    kbd_code   = c;
    local_echo = echo;
    @(negedge clk);
    kbd_new    = 1'b0;
  endtask

  task automatic cpu_send(input logic [6:0] c, input bit drop);
    int k;
    k = 0;
    while (cpu_rda !== 1'b1 && k < 300) begin @(negedge clk); k++; end
    check_eq("cpu_rda_ready", cpu_rda, 1);
    @(negedge clk);
    cpu_rd = c;
    cpu_da = 1'b1;
    k = 0;
    while (cpu_rda !== 1'b0 && k < 20) begin @(negedge clk); k++; end
    check_eq("cpu_capture", cpu_rda, 0);
    if (drop) cpu_da = 1'b0;
  endtask

  task automatic wait_dq(input int n);
    int k;
    k = 0;
    while (dq.size() < n && k < 3000) begin @(negedge clk); k++; end
    check_eq("deliver_cnt", dq.size(), n);
  endtask

  task automatic check_order();
    logic [31:0] g;
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < dq.size()) ? {25'd0, dq[i]} : 32'hFFFF;
      check_eq("order", g, exp_q[i]);
    end
    dq.delete();
    exp_q.delete();
  endtask

  task automatic idle_wait();
    repeat (30) @(negedge clk);
  endtask

  task automatic wait_sig(input string tag, input bit want_tmo, input int budget);
    int k;
    k = 0;
    while (((want_tmo ? vt_timeout : vt_da) !== 1'b1) && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_eq(tag, want_tmo ? vt_timeout : vt_da, 1);
  endtask

  // Both requesters pending together, then released; order comes from the model.
  task automatic pair_test(input logic [6:0] cc, input logic [6:0] kc);
    tmode = 1;
    fval  = 1'b0;
    repeat (2) @(negedge clk);
    kbd_strobe(kc, 1'b1);
    cpu_send(cc, 1'b1);
    repeat (5) @(negedge clk);
    if (m_last_kbd) begin
      exp_q.push_back(cc);
      exp_q.push_back(fold(kc));
    end else begin
      exp_q.push_back(fold(kc));
      exp_q.push_back(cc);
    end
    // winner then loser: the loser is served last, which equals the old value
    tmode = 0;
    wait_dq(2);
    check_order();
    idle_wait();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    cpu_da = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_last_kbd = 1'b0;
  endtask

  int k;
  int nb;
  logic [6:0] c;
  logic e;

  initial begin
    rst = 1'b1; cpu_rd = '0; cpu_da = 1'b0; kbd_new = 1'b0; kbd_code = '0;
    local_echo = 1'b0; tmode = 0; fval = 1'b1; fixed_dly = 1'b0;
    m_last_kbd = 1'b0; ovf_cnt = 0; tmo_cnt = 0;
    repeat (3) @(negedge clk);
    check_eq("rst_cpu_rda", cpu_rda, 1);
    check_eq("rst_vt_da", vt_da, 0);
    check_eq("rst_vt_rd", vt_rd, 0);
    check_eq("rst_overflow", kbd_overflow, 0);
    check_eq("rst_timeout", vt_timeout, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // CPU only, fixed terminal delays, exact latency.
    fixed_dly = 1'b1;
    @(negedge clk);
    cpu_rd = 7'h41;
    cpu_da = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("cpu_rda_e2", cpu_rda, 1);
    @(negedge clk);
    check_eq("cpu_rda_e3", cpu_rda, 0);
    check_eq("cpu_vt_da_e3", vt_da, 0);
    @(negedge clk);
    check_eq("cpu_vt_da_e4", vt_da, 0);
    @(negedge clk);
    check_eq("cpu_vt_da_e5", vt_da, 1);
    check_eq("cpu_vt_rd", vt_rd, 7'h41);
    wait_dq(1);
    check_eq("cpu_rda_busy", cpu_rda, 0);
    repeat (20) @(negedge clk);
    check_eq("cpu_rda_da_high", cpu_rda, 0);
    cpu_da = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("cpu_rda_back", cpu_rda, 1);
    exp_q.push_back(7'h41);
    check_order();
    m_last_kbd = 1'b0;
    fixed_dly = 1'b0;
    idle_wait();

    // Case folding and keyboard latency.
    @(negedge clk);
    kbd_new = 1'b1; kbd_code = 7'h61; local_echo = 1'b1;
    @(negedge clk);
    kbd_new = 1'b0;
    @(negedge clk);
    check_eq("kbd_vt_da_e2", vt_da, 0);
    @(negedge clk);
    check_eq("kbd_vt_da_e3", vt_da, 1);
    check_eq("kbd_fold_a", vt_rd, 7'h41);
    kbd_strobe(7'h7B, 1'b1);
    exp_q.push_back(fold(7'h61));
    exp_q.push_back(fold(7'h7B));
    wait_dq(2);
    check_order();
    m_last_kbd = 1'b1;
    idle_wait();

    // Round robin from reset, then after a keyboard-only transfer.
    do_reset();
    pair_test(7'h42, 7'h43);
    kbd_strobe(7'h50, 1'b1);
    exp_q.push_back(7'h50);
    wait_dq(1);
    check_order();
    m_last_kbd = 1'b1;
    idle_wait();
    pair_test(7'h44, 7'h45);

    // Overflow: terminal busy, five strobes into a four-deep FIFO.
    tmode = 1;
    fval  = 1'b0;
    repeat (2) @(negedge clk);
    ovf_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      c = 7'($urandom_range(0, 127));
      kbd_strobe(c, 1'b1);
      if (i < DEPTH) exp_q.push_back(fold(c));
    end
    repeat (3) @(negedge clk);
    check_eq("ovf_pulses", ovf_cnt, 1);
    tmode = 0;
    wait_dq(DEPTH);
    check_order();
    m_last_kbd = 1'b1;
    idle_wait();
    check_eq("ovf_after_drain", ovf_cnt, 1);

    // Randomized bursts with local_echo toggling, plus lone CPU characters.
    for (int b = 0; b < 8; b++) begin
      if ($urandom_range(0, 2) == 0) begin
        c = 7'($urandom_range(0, 127));
        cpu_send(c, 1'b1);
        exp_q.push_back(c);
        wait_dq(1);
        check_order();
        idle_wait();
      end
      nb = $urandom_range(1, DEPTH);
      for (int i = 0; i < nb; i++) begin
        c = 7'($urandom_range(0, 127));
        e = ($urandom_range(0, 3) != 0);
        kbd_strobe(c, e);
        if (e) exp_q.push_back(fold(c));
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      wait_dq(exp_q.size());
      check_order();
      idle_wait();
    end
    check_eq("rand_no_ovf", ovf_cnt, 1);

    // Timeout: terminal never acknowledges.
    tmode = 1;
    fval  = 1'b1;
    tmo_cnt = 0;
    repeat (2) @(negedge clk);
    kbd_strobe(7'h31, 1'b1);
    kbd_strobe(7'h32, 1'b1);
    wait_sig("tmo_vt_da1", 1'b0, 20);
    check_eq("tmo_vt_rd1", vt_rd, 7'h31);
    k = 0;
    while (vt_timeout !== 1'b1 && k < TMO + 20) begin @(negedge clk); k++; end
    check_eq("tmo_latency", k, TMO - 1);
    check_eq("tmo_vt_da_low", vt_da, 0);
    @(negedge clk);
    check_eq("tmo_one_cycle", vt_timeout, 0);
    wait_sig("tmo_vt_da2", 1'b0, 20);
    check_eq("tmo_next_served", vt_rd, 7'h32);
    wait_sig("tmo_second", 1'b1, TMO + 20);
    @(negedge clk);
    check_eq("tmo_pulses", tmo_cnt, 2);
    tmode = 0;
    idle_wait();
    check_eq("tmo_fifo_empty", dq.size(), 0);

    // Reset while a character is being sent.
    tmode = 1;
    fval  = 1'b1;
    repeat (2) @(negedge clk);
    cpu_send(7'h55, 1'b0);
    kbd_strobe(7'h56, 1'b1);
    kbd_strobe(7'h57, 1'b1);
    wait_sig("rst_pre_vt_da", 1'b0, 40);
    check_eq("rst_pre_rda", cpu_rda, 0);
    rst = 1'b1;
    #1;
    check_eq("rst_mid_vt_da", vt_da, 0);
    check_eq("rst_mid_rda", cpu_rda, 1);
    check_eq("rst_mid_vt_rd", vt_rd, 0);
    cpu_da = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_last_kbd = 1'b0;
    tmode = 0;
    idle_wait();
    check_eq("rst_nothing_left", dq.size(), 0);
    check_eq("rst_vt_da_idle", vt_da, 0);
    kbd_strobe(7'h62, 1'b1);
    exp_q.push_back(fold(7'h62));
    wait_dq(1);
    check_order();
    idle_wait();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/display_char_arbiter.md
# display_char_arbiter

Shares the video terminal's single character-input handshake between two requesters: the 6502 PIA display port (rd[7:1]/da/rda) and a local-echo path fed by the PS/2 keyboard decoder (ascii_new/ascii_code). It sits between the PIA pins, the keyboard decoder and video_terminal in top. It also sequences the terminal's DA/ready handshake, buffers keyboard characters, and folds lowercase to uppercase.

## Interface
Parameters:
- KBD_DEPTH, 4: keyboard FIFO depth (power of two, ≥2).
- ACK_TIMEOUT, 4096: cycles to wait for the terminal to drop vt_rdy before abandoning a character.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_rd  in  7  PIA display data, bit 6..0 = rd[7:1]; asynchronous to clk.
- cpu_da  in  1  PIA data-available level; asynchronous to clk.
- cpu_rda  out  1  high = arbiter can accept a CPU character.
- kbd_new  in  1  one-cycle strobe, synchronous to clk.
- kbd_code  in  7  ASCII, valid with kbd_new.
- local_echo  in  1  high = keyboard characters are echoed to the display.
- vt_rd  out  7  character to terminal.
- vt_da  out  1  data-available to terminal.
- vt_rdy  in  1  terminal idle/ready (high = can accept).
- kbd_overflow  out  1  one-cycle pulse when a keyboard char is dropped.
- vt_timeout  out  1  one-cycle pulse when a character is abandoned.

## Operation
- cpu_da and cpu_rd pass through 2-flop synchronizers; cpu_rd is sampled 1 cycle after the synchronized cpu_da rising edge.
- CPU holding register: on a cpu_da rise while cpu_rda=1, the character is captured, cpu_pend is set, and cpu_rda goes 0. cpu_rda returns to 1 only when the character has been delivered (or has timed out) AND the synchronized cpu_da=0.
- Keyboard path: when kbd_new=1 and local_echo=1, the code is pushed into the FIFO after case folding: 0x61..0x7A → code−0x20; all other codes pass unchanged. FIFO full on push → the character is dropped and kbd_overflow pulses. When local_echo=0, kbd_new is ignored. The FIFO is not flushed when local_echo falls.
- FSM states:
  - IDLE: if any request exists, grant one of them. With both requesting, grant the one not served last (round-robin bit, reset = CPU last, so the keyboard wins the first tie). Load vt_rd, then go to SEND.
  - SEND: vt_da=1 and vt_rd is held. When vt_rdy=0, go to RELEASE. If the counter reaches ACK_TIMEOUT, pulse vt_timeout, drop the character and go to IDLE.
  - RELEASE: vt_da=0. When vt_rdy=1, the character is complete: pop the FIFO or clear cpu_pend, update the round-robin bit, and go to IDLE.
- A timeout counts as completion for the purpose of releasing the requester.
- Push and pop in the same cycle on a full FIFO: the pop takes effect first, so no overflow occurs.

## Timing
- Reset values: cpu_rda=1, vt_da=0, vt_rd=0, kbd_overflow=0, vt_timeout=0, FIFO empty, state IDLE, cpu_pend=0.
- Reset asserted mid-transfer returns everything to these values immediately. Pending characters are lost.
- All outputs are registered.
- Latency, keyboard, with terminal ready: kbd_new at cycle 0 → FIFO write at edge 1 → IDLE grant at edge 2 → vt_da=1 from edge 3.
- Latency, CPU: 2 sync cycles + 1 edge-detect + 1 capture + 1 grant. vt_da rises 5 edges after cpu_da rises.
- vt_rd is stable from vt_da rise until RELEASE completes.
- The timeout counter clears on entry to SEND.

## Structure
- Package display_arb_pkg holds:
  - the state enum (IDLE, SEND, RELEASE);
  - LC_LO=7'h61, LC_HI=7'h7A, CASE_OFS=7'h20;
  - the source-select constants SRC_CPU and SRC_KBD.
- One sub-module, kbd_fifo: a synchronous FIFO parameterized by width and depth, with full/empty flags and simultaneous push/pop.
- The synchronizers, FSM and round-robin logic stay in display_char_arbiter.

## Test plan
- CPU only: cpu_rd=0x41, cpu_da rises; terminal model drops vt_rdy 3 cycles after vt_da and raises it 10 cycles later → vt_rd=0x41, vt_da high until vt_rdy falls; cpu_rda low until delivery and cpu_da=0.
- Case folding: local_echo=1, kbd_code=0x61 then 0x7B → vt_rd sees 0x41, then 0x7B.
- Simultaneous requests: CPU 0x42 and keyboard 0x43 pending from reset → order 0x43, 0x42. Then a second pair → order 0x44 (CPU), then keyboard.
- Overflow: vt_rdy held 0, five kbd_new strobes with KBD_DEPTH=4 → kbd_overflow pulses exactly once; four characters are later delivered in order.
- Timeout: vt_rdy held 1 forever → vt_timeout pulses at ACK_TIMEOUT cycles, vt_da falls, and the next request is served.
- Reset mid-SEND: rst asserted while vt_da=1 → vt_da=0 and cpu_rda=1 on the same cycle; the FIFO is empty after release.
